// File: rtl/reg_dump_pkg.sv
// Types and constants shared by the register dump reader, the CPU core and the register file.
package reg_dump_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int XLEN       = 32;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] READ = 2'd1;
   localparam logic [1:0] SEND = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

endpackage

// File: rtl/reg_dump.sv
// Debug reader: walks FIRST_REG..LAST_REG on a spare register file read port and
// streams each word with its index over a valid/ready interface.
//
//  state | meaning
//  IDLE  | waiting for i_start
//  READ  | o_rd_addr settled, sample i_rd_data at this edge
//  SEND  | word presented, waiting for handshake
//  DONE  | one-cycle o_done after the last word
module reg_dump
   import reg_dump_pkg::*;
#(
   parameter int ADDR_W    = REG_ADDR_W,
   parameter int DATA_W    = XLEN,
   parameter int FIRST_REG = 0,
   parameter int LAST_REG  = 31
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic              i_abort,
   output logic [ADDR_W-1:0] o_rd_addr,
   input  logic [DATA_W-1:0] i_rd_data,
   output logic [DATA_W-1:0] o_data,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_valid,
   input  logic              i_ready,
   output logic              o_last,
   output logic              o_busy,
   output logic              o_done
);

   localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_REG);
   localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_REG);

   if (FIRST_REG > LAST_REG || LAST_REG >= (1 << ADDR_W)) begin : g_param_bad
      $error("reg_dump: need FIRST_REG <= LAST_REG <= 2**ADDR_W-1");
   end

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [ADDR_W-1:0] idx;
   logic              hs;
   logic              is_last;

   assign hs      = o_valid && i_ready;
   assign is_last = (idx == LAST_A);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (i_start) state_nxt = READ;
         READ:    state_nxt = i_abort ? IDLE : SEND;
         SEND: begin
            if (i_abort)  state_nxt = IDLE;
            else if (hs)  state_nxt = is_last ? DONE : READ;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      o_busy = (state != IDLE);
      o_done = (state == DONE);
   end

   // The terminal compare precedes the increment, so idx never wraps past LAST_REG.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx       <= '0;
         o_rd_addr <= '0;
         o_data    <= '0;
         o_addr    <= '0;
         o_valid   <= 1'b0;
         o_last    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_start) begin
                  idx       <= FIRST_A;
                  o_rd_addr <= FIRST_A;
               end
            end
            READ: begin
               if (!i_abort) begin
                  o_data  <= i_rd_data;
                  o_addr  <= idx;
                  o_last  <= is_last;
                  o_valid <= 1'b1;
               end
            end
            SEND: begin
               if (i_abort) begin
                  o_valid <= 1'b0;
               end else if (hs) begin
                  o_valid <= 1'b0;
                  if (!is_last) begin
                     idx       <= idx + 1'b1;
                     o_rd_addr <= idx + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
